// File: rtl/karpentium_core_iv.sv
// Karpentium IV: multi-cycle accumulator core with unified program/data RAM,
// a fetch/decode/execute FSM, an IN handshake, a strobed OUT and a halted-only program-load port.
module karpentium_core_iv #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    output logic              halted,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_wdata,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic [ADDR_W-1:0] dbg_pc,
    output logic [DATA_W-1:0] dbg_acc
);
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [3:0] OP_NOP = 4'h0, OP_LDA = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3,
                           OP_STA = 4'h4, OP_IN  = 4'h5, OP_OUT = 4'h6, OP_JMP = 4'h7,
                           OP_JZ  = 4'h8, OP_JN  = 4'h9, OP_AND = 4'hA, OP_OR  = 4'hB,
                           OP_XOR = 4'hC, OP_SHL = 4'hD, OP_SHR = 4'hE, OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        S_HALT, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WAIT_IN
    } state_t;

    state_t             state;
    logic [DATA_W-1:0]  mem [DEPTH];
    logic [DATA_W-1:0]  rdata;
    logic [DATA_W-1:0]  acc;
    logic [ADDR_W-1:0]  pc;
    // Only the opcode and operand fields of the instruction word are kept.
    logic [3:0]         ir_op;
    logic [ADDR_W-1:0]  ir_a;

    logic [ADDR_W-1:0]  ram_addr;
    logic               ram_we;
    logic [DATA_W-1:0]  ram_wdata;

    function automatic logic [DATA_W-1:0] mem_alu(input logic [3:0] op,
                                                  input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] r;
        r = b;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            default: r = b;
        endcase
        return r;
    endfunction

    // The single RAM port is shared by program load, fetch and operand access.
    always_comb begin
        ram_addr  = pc;
        ram_we    = 1'b0;
        ram_wdata = acc;
        case (state)
            S_HALT: begin
                ram_addr  = prog_addr;
                ram_we    = prog_we;
                ram_wdata = prog_wdata;
            end
            S_EXEC: begin
                ram_addr = ir_a;
                ram_we   = (ir_op == OP_STA);
            end
            default: ram_addr = pc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (ram_we)
            mem[ram_addr] <= ram_wdata;
        rdata <= mem[ram_addr];
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state     <= S_HALT;
            pc        <= '0;
            acc       <= '0;
            ir_op     <= '0;
            ir_a      <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
            halted    <= 1'b1;
        end else begin
            out_valid <= 1'b0;
            case (state)
                S_HALT: begin
                    if (start) begin
                        state  <= S_FETCH;
                        halted <= 1'b0;
                    end
                end
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    ir_op <= rdata[DATA_W-1 -: 4];
                    ir_a  <= rdata[ADDR_W-1:0];
                    pc    <= pc + ADDR_W'(1);
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    state <= S_FETCH;
                    case (ir_op)
                        OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: state <= S_MEM;
                        OP_JMP: pc <= ir_a;
                        OP_JZ:  if (acc == '0) pc <= ir_a;
                        OP_JN:  if (acc[DATA_W-1]) pc <= ir_a;
                        OP_SHL: acc <= acc << 1;
                        OP_SHR: acc <= acc >> 1;
                        OP_OUT: begin
                            out_data  <= acc;
                            out_valid <= 1'b1;
                        end
                        OP_IN: begin
                            state    <= S_WAIT_IN;
                            in_ready <= 1'b1;
                        end
                        OP_HLT: begin
                            state  <= S_HALT;
                            halted <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    acc   <= mem_alu(ir_op, acc, rdata);
                    state <= S_FETCH;
                end
                S_WAIT_IN: begin
                    if (in_valid) begin
                        acc      <= in_data;
                        in_ready <= 1'b0;
                        state    <= S_FETCH;
                    end
                end
                default: begin
                    state  <= S_HALT;
                    halted <= 1'b1;
                end
            endcase
        end
    end

    assign dbg_pc  = pc;
    assign dbg_acc = acc;
endmodule

// File: tb/tb_karpentium_core_iv.sv
// Directed bench for karpentium_core_iv: a 16/6 core and an 8/4 core run hand-written programs.
module tb_karpentium_core_iv;
    logic clk = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        a_start = 0, a_halted, a_we = 0, a_in_valid = 0, a_in_ready, a_out_valid;
    logic [5:0]  a_addr = '0, a_pc;
    logic [15:0] a_wdata = '0, a_in_data = '0, a_out_data, a_acc;

    logic        b_start = 0, b_halted, b_we = 0, b_in_valid = 0, b_in_ready, b_out_valid;
    logic [3:0]  b_addr = '0, b_pc;
    logic [7:0]  b_wdata = '0, b_in_data = '0, b_out_data, b_acc;

    karpentium_core_iv #(.DATA_W(16), .ADDR_W(6)) u_a (
        .clk(clk), .clr(clr), .start(a_start), .halted(a_halted),
        .prog_we(a_we), .prog_addr(a_addr), .prog_wdata(a_wdata),
        .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .out_data(a_out_data), .out_valid(a_out_valid), .dbg_pc(a_pc), .dbg_acc(a_acc)
    );

    karpentium_core_iv #(.DATA_W(8), .ADDR_W(4)) u_b (
        .clk(clk), .clr(clr), .start(b_start), .halted(b_halted),
        .prog_we(b_we), .prog_addr(b_addr), .prog_wdata(b_wdata),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_valid(b_out_valid), .dbg_pc(b_pc), .dbg_acc(b_acc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // All driving tasks start and end just after a falling edge.
    task automatic load_a(input logic [5:0] addr, input logic [15:0] data);
        a_we = 1; a_addr = addr; a_wdata = data;
        @(negedge clk);
        a_we = 0;
    endtask

    task automatic load_b(input logic [3:0] addr, input logic [7:0] data);
        b_we = 1; b_addr = addr; b_wdata = data;
        @(negedge clk);
        b_we = 0;
    endtask

    task automatic start_a();
        a_start = 1;
        @(negedge clk);
        a_start = 0;
    endtask

    task automatic start_b();
        b_start = 1;
        @(negedge clk);
        b_start = 0;
    endtask

    task automatic reset_pulse();
        clr = 0;
        #2 clr = 1;
        @(negedge clk);
    endtask

    task automatic wait_halt_a(input string tag, output int pulses, output logic [15:0] last);
        pulses = 0;
        last   = '0;
        for (int i = 0; i < 200; i++) begin
            if (a_halted) break;
            if (a_out_valid) begin
                pulses++;
                last = a_out_data;
            end
            @(negedge clk);
        end
        check(tag, a_halted, 1);
    endtask

    task automatic wait_halt_b(input string tag, output int pulses,
                               output logic [7:0] first, output logic [7:0] last);
        pulses = 0;
        first  = '0;
        last   = '0;
        for (int i = 0; i < 200; i++) begin
            if (b_halted) break;
            if (b_out_valid) begin
                if (pulses == 0) first = b_out_data;
                pulses++;
                last = b_out_data;
            end
            @(negedge clk);
        end
        check(tag, b_halted, 1);
    endtask

    task automatic wait_ready_a(input string tag);
        for (int i = 0; i < 50; i++) begin
            if (a_in_ready) break;
            @(negedge clk);
        end
        check(tag, a_in_ready, 1);
    endtask

    int          np;
    logic [15:0] lo16;
    logic [7:0]  f8, l8;

    initial begin
        repeat (2) @(negedge clk);
        clr = 1;
        @(negedge clk);

        // Reset state
        check("rst_a_halted", a_halted, 1);
        check("rst_a_pc", a_pc, 0);
        check("rst_a_acc", a_acc, 0);
        check("rst_a_out_valid", a_out_valid, 0);
        check("rst_a_out_data", a_out_data, 0);
        check("rst_a_in_ready", a_in_ready, 0);
        check("rst_b_halted", b_halted, 1);
        check("rst_b_pc", b_pc, 0);

        // LDA 10, ADD 11, STA 12, OUT, HLT
        load_a(6'd10, 16'd7);
        load_a(6'd11, 16'd5);
        load_a(6'd0, 16'h100A);
        load_a(6'd1, 16'h200B);
        load_a(6'd2, 16'h400C);
        load_a(6'd3, 16'h6000);
        load_a(6'd4, 16'hF000);
        start_a();
        wait_halt_a("t2_halt", np, lo16);
        check("t2_pulses", np, 1);
        check("t2_out_data", lo16, 16'd12);
        check("t2_out_held", a_out_data, 16'd12);
        check("t2_mem12", u_a.mem[12], 16'd12);
        check("t2_pc", a_pc, 6'd5);
        check("t2_acc", a_acc, 16'd12);

        // SUB wraps negative, JN taken to a HLT at 6
        reset_pulse();
        load_a(6'd10, 16'd3);
        load_a(6'd11, 16'd5);
        load_a(6'd0, 16'h100A);
        load_a(6'd1, 16'h300B);
        load_a(6'd2, 16'h9006);
        load_a(6'd3, 16'hF000);
        load_a(6'd6, 16'hF000);
        start_a();
        wait_halt_a("t3_halt", np, lo16);
        check("t3_acc", a_acc, 16'hFFFE);
        check("t3_pc", a_pc, 6'd7);

        // JZ not taken with ACC=1, then resume and JZ taken with ACC=0
        reset_pulse();
        load_a(6'd13, 16'd1);
        load_a(6'd14, 16'd0);
        load_a(6'd0, 16'h100D);
        load_a(6'd1, 16'h8006);
        load_a(6'd2, 16'hF000);
        load_a(6'd3, 16'h100E);
        load_a(6'd4, 16'h8008);
        load_a(6'd5, 16'hF000);
        load_a(6'd8, 16'hF000);
        start_a();
        wait_halt_a("t3_jz_halt", np, lo16);
        check("t3_jz_nt_pc", a_pc, 6'd3);
        check("t3_jz_nt_acc", a_acc, 16'd1);
        start_a();
        wait_halt_a("t3_jz2_halt", np, lo16);
        check("t3_jz_t_pc", a_pc, 6'd9);
        check("t3_jz_t_acc", a_acc, 16'd0);

        // IN handshake; early in_valid must not be latched
        reset_pulse();
        load_a(6'd10, 16'h1234);
        load_a(6'd0, 16'h100A);
        load_a(6'd1, 16'h5000);
        load_a(6'd2, 16'h6000);
        load_a(6'd3, 16'hF000);
        start_a();
        a_in_data = 16'hBEEF;
        a_in_valid = 1;
        repeat (2) @(negedge clk);
        a_in_valid = 0;
        wait_ready_a("t4_ready_seen");
        check("t4_acc_before", a_acc, 16'h1234);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_hold_ready", a_in_ready, 1);
            check("t4_hold_acc", a_acc, 16'h1234);
        end
        a_in_data = 16'h00A5;
        a_in_valid = 1;
        @(negedge clk);
        a_in_valid = 0;
        check("t4_acc_in", a_acc, 16'h00A5);
        check("t4_ready_drop", a_in_ready, 0);
        wait_halt_a("t4_halt", np, lo16);
        check("t4_out", lo16, 16'h00A5);
        check("t4_pulses", np, 1);

        // Asynchronous reset while waiting for input
        reset_pulse();
        start_a();
        wait_ready_a("t1_ready_seen");
        clr = 0;
        #1;
        check("t1_halted", a_halted, 1);
        check("t1_pc", a_pc, 0);
        check("t1_acc", a_acc, 0);
        check("t1_out_valid", a_out_valid, 0);
        check("t1_in_ready", a_in_ready, 0);
        @(negedge clk);
        clr = 1;
        @(negedge clk);
        check("t1_still_halted", a_halted, 1);
        check("t1_ram_kept", u_a.mem[10], 16'h1234);

        // PC wrap on the 8/4 core; writes while running are dropped
        load_b(4'd12, 8'h81);
        load_b(4'd0, 8'h82);
        load_b(4'd1, 8'hF0);
        load_b(4'd2, 8'h1C);
        load_b(4'd3, 8'h7F);
        load_b(4'd15, 8'h00);
        start_b();
        b_we = 1; b_addr = 4'd12; b_wdata = 8'h55;
        repeat (3) @(negedge clk);
        b_we = 0;
        wait_halt_b("t5_halt", np, f8, l8);
        check("t5_pc", b_pc, 4'd2);
        check("t5_acc", b_acc, 8'h81);
        check("t5_mem12", u_b.mem[12], 8'h81);

        // SHL/SHR/XOR on 8 bits; word 0 written in the same cycle as start
        reset_pulse();
        load_b(4'd13, 8'hFF);
        load_b(4'd1, 8'hD0);
        load_b(4'd2, 8'h60);
        load_b(4'd3, 8'hE0);
        load_b(4'd4, 8'h60);
        load_b(4'd5, 8'hCD);
        load_b(4'd6, 8'hF0);
        b_we = 1; b_addr = 4'd0; b_wdata = 8'h1C; b_start = 1;
        @(negedge clk);
        b_we = 0; b_start = 0;
        wait_halt_b("t6_halt", np, f8, l8);
        check("t6_pulses", np, 2);
        check("t6_shl", f8, 8'h02);
        check("t6_shr", l8, 8'h01);
        check("t6_xor", b_acc, 8'hFE);
        check("t6_pc", b_pc, 4'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
